// File: rtl/circuit_b_bist.sv
// BIST controller for a 3-input/2-output combinational CUT: exhaustive
// binary-count stimulus on A,B,C, MISR compaction of Y,Z, golden compare.
module circuit_b_bist #(
  parameter int                NPAT   = 8,
  parameter int                MISR_W = 8,
  parameter logic [MISR_W-1:0] POLY   = 8'h1D,
  parameter logic [MISR_W-1:0] GOLDEN = 8'hCC
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  output logic              A,
  output logic              B,
  output logic              C,
  input  logic              Y,
  input  logic              Z,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic [MISR_W-1:0] SIG,
  output logic [1:0]        fsm_state
);

  // Handshake: START is a request sampled on each rising edge and is only
  // accepted in IDLE (BUSY=0). BUSY stays high for the whole run including
  // the compare cycle; DONE is a one-cycle completion strobe qualifying PASS.
  // PASS then holds until the next accepted START clears it.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_CMP  = 2'd2
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(NPAT - 1);

  state_t            state_q, state_d;
  logic [7:0]        idx_q, idx_d, idx_inc;
  logic [2:0]        pat_q, pat_d;
  logic [MISR_W-1:0] sig_q, sig_d, misr_next;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  assign idx_inc = idx_q + 8'd1;

  // One MISR step: shift left, fold the MSB back through the tap mask, and
  // inject the CUT response with Y on bit 1 and Z on bit 0.
  always_comb begin
    misr_next = {sig_q[MISR_W-2:0], 1'b0};
    if (sig_q[MISR_W-1]) begin
      misr_next = misr_next ^ POLY;
    end
    misr_next = misr_next ^ {{(MISR_W-2){1'b0}}, Y, Z};
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    sig_d   = sig_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          sig_d   = '0;
          idx_d   = '0;
          pat_d   = '0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sig_d = misr_next;
        if (idx_q == LAST_IDX) begin
          state_d = S_CMP;
        end else begin
          idx_d = idx_inc;
          // Patterns count modulo 8, so runs longer than 8 wrap 111->000.
          pat_d = idx_inc[2:0];
        end
      end
      S_CMP: begin
        pass_d  = (sig_q == GOLDEN);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pat_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      pat_q   <= '0;
      sig_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      sig_q   <= sig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign A         = pat_q[2];
  assign B         = pat_q[1];
  assign C         = pat_q[0];
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign PASS      = pass_q;
  assign SIG       = sig_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_circuit_b_bist.sv
// Self-checking bench for circuit_b_bist: three instances (NPAT = 8, 9, 1)
// driving a table-programmable CUT model, checked against vectors and a model.
module tb_circuit_b_bist;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  // CUT truth tables indexed by {A,B,C}; shared by all instances.
  logic [7:0] ytab = 8'h00;
  logic [7:0] ztab = 8'h33;

  logic start8 = 1'b0, start9 = 1'b0, start1 = 1'b0;
  logic a8, b8, c8, y8, z8, busy8, done8, pass8;
  logic a9, b9, c9, y9, z9, busy9, done9, pass9;
  logic a1, b1, c1, y1, z1, busy1, done1, pass1;
  logic [7:0] sig8, sig9, sig1;
  logic [1:0] st8, st9, st1;

  assign y8 = ytab[{a8, b8, c8}];
  assign z8 = ztab[{a8, b8, c8}];
  assign y9 = ytab[{a9, b9, c9}];
  assign z9 = ztab[{a9, b9, c9}];
  assign y1 = ytab[{a1, b1, c1}];
  assign z1 = ztab[{a1, b1, c1}];

  circuit_b_bist #(.NPAT(8)) dut8 (
    .CLK(CLK), .RST_N(RST_N), .START(start8), .A(a8), .B(b8), .C(c8),
    .Y(y8), .Z(z8), .BUSY(busy8), .DONE(done8), .PASS(pass8), .SIG(sig8),
    .fsm_state(st8));
  circuit_b_bist #(.NPAT(9)) dut9 (
    .CLK(CLK), .RST_N(RST_N), .START(start9), .A(a9), .B(b9), .C(c9),
    .Y(y9), .Z(z9), .BUSY(busy9), .DONE(done9), .PASS(pass9), .SIG(sig9),
    .fsm_state(st9));
  circuit_b_bist #(.NPAT(1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .START(start1), .A(a1), .B(b1), .C(c1),
    .Y(y1), .Z(z1), .BUSY(busy1), .DONE(done1), .PASS(pass1), .SIG(sig1),
    .fsm_state(st1));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: signature after nsteps patterns, straight from the MISR rule.
  function automatic logic [7:0] model_sig(input logic [7:0] yt, input logic [7:0] zt, input int nsteps);
    int s = 0;
    for (int k = 0; k < nsteps; k++) begin
      int p = k % 8;
      int fb = ((s >> 7) & 1) ? 'h1D : 0;
      s = ((s << 1) & 'hFF) ^ fb ^ (int'(yt[p]) * 2 + int'(zt[p]));
    end
    return 8'(s);
  endfunction

  function automatic logic [63:0] model_steps(input logic [7:0] yt, input logic [7:0] zt);
    logic [63:0] r = '0;
    for (int k = 0; k < 8; k++) r[63-8*k -: 8] = model_sig(yt, zt, k + 1);
    return r;
  endfunction

  task automatic wait_done8(output int cyc);
    cyc = 0;
    while (done8 !== 1'b1 && cyc < 60) begin
      @(negedge CLK);
      cyc++;
    end
    check("done8_timeout", 32'(cyc < 60), 32'd1);
  endtask

  // Full NPAT=8 run with per-cycle checks; optional random START injection.
  task automatic run8(input logic [7:0] yt, input logic [7:0] zt, input logic [63:0] steps,
                      input logic exp_pass, input bit inject);
    ytab = yt;
    ztab = zt;
    @(negedge CLK);
    start8 = 1'b1;
    @(negedge CLK);
    start8 = 1'b0;
    check("run_busy", 32'(busy8), 32'd1);
    check("run_sig0", 32'(sig8), 32'd0);
    check("run_pass_clr", 32'(pass8), 32'd0);
    for (int k = 0; k < 8; k++) begin
      check("run_pat", 32'({a8, b8, c8}), 32'(k % 8));
      if (inject) start8 = 1'($urandom_range(0, 1));
      @(negedge CLK);
      check("run_sig", 32'(sig8), 32'(steps[63-8*k -: 8]));
    end
    start8 = 1'b0;
    check("cmp_busy", 32'(busy8), 32'd1);
    check("cmp_done", 32'(done8), 32'd0);
    @(negedge CLK);
    check("done_pulse", 32'(done8), 32'd1);
    check("done_pass", 32'(pass8), 32'(exp_pass));
    check("done_busy", 32'(busy8), 32'd0);
    check("done_pat", 32'({a8, b8, c8}), 32'd0);
    check("done_sig", 32'(sig8), 32'(steps[7:0]));
    @(negedge CLK);
    check("done_drop", 32'(done8), 32'd0);
    check("pass_hold", 32'(pass8), 32'(exp_pass));
    check("sig_hold", 32'(sig8), 32'(steps[7:0]));
  endtask

  typedef struct {
    logic [7:0]  yt;
    logic [7:0]  zt;
    logic [63:0] steps;
    logic        exp_pass;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int cyc;
    logic [7:0] ry, rz;
    logic [63:0] rs;

    // Fault-free CUT (Y=0, Z=~B), Z stuck-at-1, Y=1/Z=0, Y=Z=1.
    vecs[0] = '{8'h00, 8'h33, 64'h01_03_06_0C_19_33_66_CC, 1'b1};
    vecs[1] = '{8'h00, 8'hFF, 64'h01_03_07_0F_1F_3F_7F_FF, 1'b0};
    vecs[2] = '{8'hFF, 8'h00, 64'h02_06_0E_1E_3E_7E_FE_E3, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 64'h03_05_09_11_21_41_81_1C, 1'b0};

    #3;
    check("rst_pat", 32'({a8, b8, c8}), 32'd0);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_pass", 32'(pass8), 32'd0);
    check("rst_sig", 32'(sig8), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 4; i++) begin
      run8(vecs[i].yt, vecs[i].zt, vecs[i].steps, vecs[i].exp_pass, i[0]);
    end

    for (int i = 0; i < 6; i++) begin
      ry = 8'($urandom_range(0, 255));
      rz = 8'($urandom_range(0, 255));
      rs = model_steps(ry, rz);
      run8(ry, rz, rs, (rs[7:0] == 8'hCC), 1'b1);
    end

    // START in the DONE cycle restarts immediately.
    ytab = 8'h00;
    ztab = 8'h33;
    start8 = 1'b1;
    @(negedge CLK);
    start8 = 1'b0;
    wait_done8(cyc);
    check("dc_pass", 32'(pass8), 32'd1);
    start8 = 1'b1;
    @(negedge CLK);
    start8 = 1'b0;
    check("dc_done_drop", 32'(done8), 32'd0);
    check("dc_pass_clr", 32'(pass8), 32'd0);
    check("dc_busy", 32'(busy8), 32'd1);
    wait_done8(cyc);
    check("dc_cycles", 32'(cyc), 32'd9);
    check("dc_sig", 32'(sig8), 32'hCC);
    check("dc_pass2", 32'(pass8), 32'd1);

    // START held high: back-to-back runs every NPAT+2 cycles.
    @(negedge CLK);
    start8 = 1'b1;
    wait_done8(cyc);
    for (int r = 0; r < 2; r++) begin
      @(negedge CLK);
      wait_done8(cyc);
      check("b2b_interval", 32'(cyc + 1), 32'd10);
      check("b2b_sig", 32'(sig8), 32'hCC);
      check("b2b_pass", 32'(pass8), 32'd1);
    end
    start8 = 1'b0;
    @(negedge CLK);
    check("b2b_stop", 32'(busy8), 32'd0);

    // Asynchronous reset at idx=4, then a clean run.
    start8 = 1'b1;
    @(negedge CLK);
    start8 = 1'b0;
    repeat (4) @(negedge CLK);
    check("mid_pat4", 32'({a8, b8, c8}), 32'd4);
    #2;
    RST_N = 1'b0;
    #1;
    check("ar_pat", 32'({a8, b8, c8}), 32'd0);
    check("ar_busy", 32'(busy8), 32'd0);
    check("ar_sig", 32'(sig8), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    cyc = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      if (done8 === 1'b1) cyc++;
    end
    check("ar_no_done", 32'(cyc), 32'd0);
    run8(8'h00, 8'h33, model_steps(8'h00, 8'h33), 1'b1, 1'b0);

    // NPAT=9 with Z stuck-at-1: wrap to 000 and MISR feedback.
    ytab = 8'h00;
    ztab = 8'hFF;
    start9 = 1'b1;
    @(negedge CLK);
    start9 = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (k == 8) check("n9_wrap_pat", 32'({a9, b9, c9}), 32'd0);
      @(negedge CLK);
      if (k == 7) check("n9_sig8", 32'(sig9), 32'hFF);
    end
    check("n9_sig", 32'(sig9), 32'hE2);
    check("n9_model", 32'(sig9), 32'(model_sig(8'h00, 8'hFF, 9)));
    @(negedge CLK);
    check("n9_done", 32'(done9), 32'd1);
    check("n9_pass", 32'(pass9), 32'd0);

    // NPAT=1 with Y=1, Z=0: BUSY exactly two cycles.
    ytab = 8'hFF;
    ztab = 8'h00;
    @(negedge CLK);
    start1 = 1'b1;
    @(negedge CLK);
    start1 = 1'b0;
    check("n1_busy_a", 32'(busy1), 32'd1);
    @(negedge CLK);
    check("n1_busy_b", 32'(busy1), 32'd1);
    check("n1_sig", 32'(sig1), 32'h02);
    @(negedge CLK);
    check("n1_busy_end", 32'(busy1), 32'd0);
    check("n1_done", 32'(done1), 32'd1);
    check("n1_pass", 32'(pass1), 32'd0);
    @(negedge CLK);
    check("n1_done_drop", 32'(done1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/circuit_b_bist.md
# circuit_b_bist

Built-in self-test controller for the three-input / two-output combinational circuit under test (CUT).
- Upstream side: drives an exhaustive binary-count pattern onto the CUT inputs A, B, C.
- Downstream side: compacts the CUT responses Y, Z into a multiple-input signature register (MISR).
- At end of run: compares the signature against a golden value and reports pass/fail through a start/busy/done handshake.

## Interface
Parameters:
- NPAT, default 8: patterns applied per run; legal range 1..255.
- MISR_W, default 8: signature width; legal range 4..16.
- POLY, default 8'h1D: MISR feedback tap mask, MISR_W bits wide.
- GOLDEN, default 8'hCC: expected final signature, MISR_W bits wide.

Ports:
- CLK  input  1  single clock; all flops rising-edge.
- RST_N  input  1  reset, asynchronous, active-low.
- START  input  1  run request; sampled on the rising edge; ignored while BUSY=1.
- A, B, C  output  1 each  CUT stimulus; registered.
- Y, Z  input  1 each  CUT responses; sampled on the rising edge; an undriven Y is tied 0 at the top level.
- BUSY  output  1  high while a run is in progress.
- DONE  output  1  one-cycle pulse at end of run.
- PASS  output  1  result of the last run; valid when DONE=1; held until the next START.
- SIG  output  MISR_W  current signature register.

## Operation
States:
- IDLE: wait for START.
- RUN: apply patterns and compact responses.
- CMP: compare signature and report.

Reset:
- Asynchronous on RST_N low.
- State=IDLE, pattern index idx=0, {A,B,C}=3'b000, BUSY=0, DONE=0, PASS=0, SIG=0.

IDLE:
- DONE=0 except in the cycle immediately following CMP.
- START=1 at an edge: SIG<=0, idx<=0, {A,B,C}<=3'b000, PASS<=0, BUSY<=1, go to RUN.

RUN, at every edge:
- SIG <= (SIG<<1) ^ (SIG[MISR_W-1] ? POLY : 0) ^ {0…0, Y, Z}, with Y into bit 1 and Z into bit 0.
- If idx==NPAT-1: hold {A,B,C}; go to CMP.
- Otherwise: idx<=idx+1; {A,B,C}<=(idx+1) mod 8, with A as MSB.

CMP, one cycle:
- PASS<=(SIG==GOLDEN), DONE<=1, BUSY<=0, {A,B,C}<=3'b000.
- SIG holds; go to IDLE.

Boundary cases:
- START while BUSY=1: no effect.
- START in the DONE cycle: accepted, since state is IDLE; DONE drops, PASS clears, and a new run starts.
- NPAT>8: pattern wraps 111→000 and continues counting.
- RST_N low mid-run: immediate return to reset values; no DONE is produced.

## Timing
- Edge e0 samples START. Pattern k is driven from edge e0+k and absorbed at edge e0+k+1, for k=0..NPAT-1.
- CMP occupies the cycle after edge e0+NPAT. DONE=1 and PASS are valid after edge e0+NPAT+1, and DONE drops at edge e0+NPAT+2.
- BUSY is high from e0 to e0+NPAT+1, i.e. NPAT+1 cycles.
- Y/Z path: a combinational CUT between the registered A,B,C and the MISR input; a single-cycle path.
- SIG is visible every cycle. Its final value is stable from edge e0+NPAT until the next START.

## Test plan
- Exhaustive run with the fault-free CUT, Y tied 0, NPAT=8: Z sequence is 1,1,0,0,1,1,0,0; SIG steps 01,03,06,0C,19,33,66,CC; PASS=1; DONE pulses exactly once, after edge e0+9.
- Z stuck-at-1, NPAT=8: SIG sequence 01,03,07,0F,1F,3F,7F,FF; final SIG=0xFF; PASS=0.
- Z stuck-at-1 with NPAT=9 (wrap and MISR feedback): 9th pattern is {A,B,C}=000; SIG goes 0xFF→0xE2; PASS=0 against GOLDEN=0xCC.
- Y=1, Z=0, NPAT=1: SIG=0x02 after edge e0+1; BUSY high for exactly 2 cycles.
- START held high continuously: runs execute back-to-back, with one DONE pulse every NPAT+2 cycles. START pulses injected mid-run change neither idx nor SIG.
- RST_N asserted asynchronously at idx=4: A=B=C=0, BUSY=0, SIG=0 immediately, with no clock edge needed. No DONE follows. The next START gives a full, correct run with SIG=0xCC.
